// File: rtl/des_out_collector_if.sv
// des_out_collector_if
//   Bundles the collector's data-path signals.
//   Core side:    in_valid, core_out.
//   Display side: rd_next, slice_out, slice_idx, slice_valid,
//                 fifo_count, overflow, parity_out.
//   Modports:
//     master - the board/test side. Drives the inputs and observes the results.
//     slave  - the collector itself.
interface des_out_collector_if #(
    parameter int CW = 3
);
    logic          in_valid;
    logic [63:0]   core_out;
    logic          rd_next;
    logic [15:0]   slice_out;
    logic [1:0]    slice_idx;
    logic          slice_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          parity_out;

    modport master (
        output in_valid, core_out, rd_next,
        input  slice_out, slice_idx, slice_valid, fifo_count, overflow, parity_out
    );

    modport slave (
        input  in_valid, core_out, rd_next,
        output slice_out, slice_idx, slice_valid, fifo_count, overflow, parity_out
    );
endinterface

// File: rtl/des_out_collector.sv
// des_out_collector
//   Reader for the 64-bit result bus of the pipelined 3DES core.
//   - A PIPE_LAT-deep shift register follows in_valid through the core's
//     pipeline. When the delayed strobe appears, core_out is captured.
//   - Captured results go into a DEPTH x 64 circular FIFO.
//   - The head entry is shown 16 bits at a time, MSB slice first.
//     Each rd_next pulse advances to the next slice. The fourth pulse pops
//     the head entry.
// Ports:
//   clk   - system clock. All logic is rising-edge.
//   reset - asynchronous active-low reset.
//   bus   - des_out_collector_if.slave (see the interface file).
// Optional feature, DES_OUT_PARITY_EN:
//   Each entry stores the XOR-reduction of its 64 bits.
//   parity_out then shows the stored bit of the head entry while a slice is
//   valid. When the macro is not defined, parity_out is tied to 0.
module des_out_collector #(
    parameter int PIPE_LAT = 16,
    parameter int DEPTH    = 4,
    parameter int CW       = 3
) (
    input logic                clk,
    input logic                reset,
    des_out_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SHOW} state_t;

    // ---------------- delay line ----------------
    logic [PIPE_LAT-1:0] dly_q, dly_d;
    logic                cap;

    always_comb begin
        dly_d    = dly_q << 1;
        dly_d[0] = bus.in_valid;
    end

    assign cap = dly_q[PIPE_LAT-1];

    // ---------------- FIFO ----------------
    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, pop, do_push, head_byp;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = (state_q == SHOW) && bus.rd_next && (idx_q == 2'd3);

    // A push into a full FIFO is allowed only when a pop frees a slot in
    // the same cycle.
    assign do_push = cap && (!full || pop);

    // The next head is the entry being written this cycle. This happens when
    // the FIFO is empty after any pop, so the head must bypass the memory.
    assign head_byp = do_push && (wr_ptr_q == rd_ptr_d);

    always_comb begin
        count_d = count_q;
        if (do_push && !pop)
            count_d = count_q + 1'b1;
        else if (!do_push && pop)
            count_d = count_q - 1'b1;
        wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | (cap && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= bus.core_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dly_q      <= dly_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- readout FSM ----------------
    logic [63:0] head_nxt;
    logic [15:0] slice_q, slice_d;
    logic        valid_q, valid_d;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = SHOW;
                    idx_d   = 2'd0;
                end
            end
            SHOW: begin
                if (bus.rd_next) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        idx_d   = 2'd0;
                        // count_d already reflects the pop and any push
                        // in this cycle.
                        state_d = (count_d != '0) ? SHOW : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Outputs are computed from next-state values so that they come
    // straight out of flops.
    always_comb begin
        head_nxt = head_byp ? bus.core_out : mem_q[rd_ptr_d];
        valid_d  = (state_d == SHOW);
        slice_d  = 16'h0;
        if (valid_d) begin
            case (idx_d)
                2'd0:    slice_d = head_nxt[63:48];
                2'd1:    slice_d = head_nxt[47:32];
                2'd2:    slice_d = head_nxt[31:16];
                default: slice_d = head_nxt[15:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slice_q <= 16'h0;
            valid_q <= 1'b0;
        end else begin
            slice_q <= slice_d;
            valid_q <= valid_d;
        end
    end

    assign bus.slice_out   = slice_q;
    assign bus.slice_idx   = idx_q;
    assign bus.slice_valid = valid_q;
    assign bus.fifo_count  = count_q;
    assign bus.overflow    = overflow_q;

`ifdef DES_OUT_PARITY_EN
    logic [DEPTH-1:0] par_mem_q;
    logic             parity_q, parity_d;

    always_ff @(posedge clk) begin
        if (do_push)
            par_mem_q[wr_ptr_q] <= ^bus.core_out;
    end

    always_comb begin
        parity_d = 1'b0;
        if (valid_d)
            parity_d = head_byp ? ^bus.core_out : par_mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            parity_q <= 1'b0;
        else
            parity_q <= parity_d;
    end

    assign bus.parity_out = parity_q;
`else
    assign bus.parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_des_out_collector.sv
module tb_des_out_collector;
    localparam int P  = 16;
    localparam int D  = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    des_out_collector_if #(.CW(CW)) bus ();

    des_out_collector #(.PIPE_LAT(P), .DEPTH(D), .CW(CW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    // ---------- behavioural model: queues of due times and held results ----------
    int          due_q[$];
    logic [63:0] mq[$];
    int          edge_n  = 0;
    bit          m_show  = 0;
    int          m_idx   = 0;
    bit          m_ovf   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            due_q.delete();
            mq.delete();
            m_show = 0;
            m_idx  = 0;
            m_ovf  = 0;
        end else begin
            bit cap, pop;
            int old_sz;
            cap    = (due_q.size() > 0) && (due_q[0] == edge_n);
            if (cap) void'(due_q.pop_front());
            if (bus.in_valid) due_q.push_back(edge_n + P);
            edge_n++;
            old_sz = mq.size();
            pop    = m_show && bus.rd_next && (m_idx == 3);
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (old_sz == D && !pop) m_ovf = 1;
                else mq.push_back(bus.core_out);
            end
            if (!m_show) begin
                if (old_sz > 0) begin
                    m_show = 1;
                    m_idx  = 0;
                end
            end else if (bus.rd_next) begin
                if (m_idx < 3) m_idx++;
                else begin
                    m_idx  = 0;
                    m_show = (mq.size() > 0);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Compare DUT against the model every cycle, away from the rising edge.
    always begin
        logic [63:0] h;
        logic [15:0] e_slice;
        bit          e_par;
        @(negedge clk);
        #1;
        h       = (m_show && mq.size() > 0) ? mq[0] : 64'h0;
        e_slice = m_show ? h[63-16*m_idx -: 16] : 16'h0;
`ifdef DES_OUT_PARITY_EN
        e_par   = m_show ? ^h : 1'b0;
`else
        e_par   = 1'b0;
`endif
        chk("m_valid", bus.slice_valid, m_show);
        chk("m_slice", bus.slice_out, e_slice);
        chk("m_idx",   bus.slice_idx, m_idx);
        chk("m_count", bus.fifo_count, mq.size());
        chk("m_ovf",   bus.overflow, m_ovf);
        chk("m_par",   bus.parity_out, e_par);
    end

    // ---------- stimulus helpers ----------
    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic rd();
        bus.rd_next = 1'b1;
        step();
        bus.rd_next = 1'b0;
        step();
    endtask

    // One issue, then present val on core_out exactly P cycles later.
    task automatic issue_cap(input logic [63:0] val);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (P - 1) step();
        bus.core_out = val;
        step();
        bus.core_out = 64'h0;
    endtask

    task automatic wait_valid(input string nm, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (bus.slice_valid) break;
            step();
        end
        chk(nm, bus.slice_valid, 1'b1);
    endtask

    // ---------- directed sequence ----------
    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.core_out = 64'h0;
        bus.rd_next  = 1'b0;
        repeat (3) step();
        chk("rst_valid", bus.slice_valid, 1'b0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ovf",   bus.overflow, 1'b0);
        rst_n = 1'b1;
        repeat (6) step();

        // single issue, four slices
        issue_cap(64'h0123_4567_89AB_CDEF);
        wait_valid("t1_wait", 10);
        chk("t1_s0", bus.slice_out, 16'h0123);
        chk("t1_i0", bus.slice_idx, 2'd0);
        rd(); chk("t1_s1", bus.slice_out, 16'h4567);
        rd(); chk("t1_s2", bus.slice_out, 16'h89AB);
        rd(); chk("t1_s3", bus.slice_out, 16'hCDEF);
        chk("t1_i3", bus.slice_idx, 2'd3);
        rd();
        chk("t1_empty_v", bus.slice_valid, 1'b0);
        chk("t1_empty_c", bus.fifo_count, 0);

        // latency alignment: core_out carries the cycle number after issue
        bus.in_valid = 1'b1;
        bus.core_out = 64'h0;
        step();
        bus.in_valid = 1'b0;
        for (int j = 1; j <= P + 4; j++) begin
            bus.core_out = 64'(j);
            step();
        end
        wait_valid("lat_wait", 10);
        rd(); rd(); rd();
        chk("lat_val", bus.slice_out, 16'(P));
        rd();

        // overflow: five back-to-back issues, no reads
        for (int j = 0; j <= P + 6; j++) begin
            bus.in_valid = (j < 5);
            bus.core_out = 64'hBEEF_0000_0000_0000 + 64'(j);
            step();
        end
        bus.core_out = 64'h0;
        chk("ovf_count", bus.fifo_count, 3'd4);
        chk("ovf_flag",  bus.overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_hi", bus.slice_out, 16'hBEEF);
            rd(); rd(); rd();
            chk("ovf_order", bus.slice_out, 16'(P + i));
            rd();
        end
        chk("ovf_drain", bus.fifo_count, 0);
        chk("ovf_sticky", bus.overflow, 1'b1);

        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        chk("ovf_cleared", bus.overflow, 1'b0);

        // full FIFO with a pop coinciding with a capture
        for (int j = 0; j <= P + 4; j++) begin
            bus.in_valid = (j < 4);
            bus.core_out = 64'hC0DE_0000_0000_0000 + 64'(j);
            step();
        end
        chk("fp_full", bus.fifo_count, 3'd4);
        bus.in_valid = 1'b1;
        bus.core_out = 64'h0;
        step();
        bus.in_valid = 1'b0;
        for (int j = 1; j <= P; j++) begin
            bus.rd_next  = (j == 2 || j == 4 || j == 6 || j == P);
            bus.core_out = 64'h5555_0000_0000_0000 + 64'(j);
            step();
        end
        bus.rd_next  = 1'b0;
        bus.core_out = 64'h0;
        step();
        chk("fp_count", bus.fifo_count, 3'd4);
        chk("fp_noovf", bus.overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(); rd(); rd();
            chk("fp_order", bus.slice_out, (i < 3) ? 16'(P + 1 + i) : 16'(P));
            rd();
        end
        chk("fp_drain", bus.fifo_count, 0);

        // reset in the middle of readout, with an issue still in flight
        for (int j = 0; j <= P + 4; j++) begin
            bus.in_valid = (j < 3);
            bus.core_out = 64'hAAAA_0000_0000_0000 + 64'(j);
            step();
        end
        rd(); rd();
        chk("mr_idx", bus.slice_idx, 2'd2);
        chk("mr_cnt", bus.fifo_count, 3'd3);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_valid0", bus.slice_valid, 1'b0);
        chk("mr_slice0", bus.slice_out, 16'h0);
        chk("mr_idx0",   bus.slice_idx, 2'd0);
        chk("mr_cnt0",   bus.fifo_count, 0);
        step(); step();
        rst_n = 1'b1;
        bus.core_out = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (P + 8) step();
        bus.core_out = 64'h0;
        chk("mr_stale_v", bus.slice_valid, 1'b0);
        chk("mr_stale_c", bus.fifo_count, 0);

        // parity of stored entries
        issue_cap(64'h1);
        issue_cap(64'h3);
        wait_valid("par_wait1", 10);
`ifdef DES_OUT_PARITY_EN
        chk("par_first", bus.parity_out, 1'b1);
`else
        chk("par_first", bus.parity_out, 1'b0);
`endif
        rd(); rd(); rd();
        chk("par_s3", bus.slice_out, 16'h0001);
        rd();
        wait_valid("par_wait2", 10);
        chk("par_second", bus.parity_out, 1'b0);
        rd(); rd(); rd();
        chk("par_s3b", bus.slice_out, 16'h0003);
        rd();
        chk("par_drain", bus.fifo_count, 0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/des_out_collector.md
Name: des_out_collector

Overview:
- Consumer-side companion to the pipelined 3DES core wrappers: the reader for the 64-bit core output bus that the board top drives.
- Tracks issued blocks through the core's fixed pipeline latency and captures each result into a small FIFO.
- Presents results 16 bits at a time to board LEDs/display under a simple read-advance handshake.
- Sits between the des3 core output and the board I/O in the encrypted-IP test tops.

Parameters:
- PIPE_LAT, 16, core latency in clk cycles from in_valid to result on core_out; legal range 1..64
- DEPTH, 4, FIFO entries; power of two, 2..16
- CW, 3, count width = log2(DEPTH)+1

Ports:
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  asynchronous active-low reset (0 = reset)
- in_valid  input  1  pulses high in the cycle a block is presented to the core input
- core_out  input  64  core result bus
- rd_next  input  1  single-cycle request to advance to the next 16-bit slice
- slice_out  output  16  currently displayed slice
- slice_idx  output  2  slice index: 0 = bits [63:48], 3 = bits [15:0]
- slice_valid  output  1  slice_out holds real data
- fifo_count  output  CW  entries held, including the one being displayed
- overflow  output  1  sticky; a captured result was dropped
- parity_out  output  1  see Optional Feature

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; delay line cleared; FIFO empty; FSM in IDLE.
- Delay line: PIPE_LAT-bit shift register fed by in_valid.
  - cap = tap at stage PIPE_LAT, i.e. in_valid delayed exactly PIPE_LAT cycles.
  - When cap=1, core_out sampled that same cycle is pushed.
- FIFO:
  - Circular, DEPTH x 64, write/read pointers wrap modulo DEPTH.
  - Push when full: data dropped, overflow set (cleared only by reset), count unchanged.
  - Push and pop in the same cycle when full: both performed, no overflow.
  - Push and pop in the same cycle when count=1: pop then push; new entry becomes head next cycle.
- Readout FSM:
  - IDLE:
    - slice_valid=0.
    - If count>0 -> SHOW next cycle with slice_idx=0.
  - SHOW:
    - slice_out = head[63-16*slice_idx -: 16]; slice_valid=1.
    - rd_next with slice_idx<3: slice_idx+1.
    - rd_next with slice_idx=3: pop head, slice_idx=0. Stay in SHOW if remaining count>0, else -> IDLE.
    - rd_next is ignored in IDLE.
  - Outputs are registered: slice_out changes the cycle after the rd_next edge.
- fifo_count: registered; updates the cycle after push/pop.
- Reset mid-operation: pending delay-line entries, FIFO contents and the FSM are all discarded immediately.
- in_valid may assert every cycle; sustained throughput is limited only by the readout rate.

Optional Feature:
- Macro: DES_OUT_PARITY_EN
- Defined:
  - Each FIFO entry stores 1 extra bit, the XOR-reduction of the captured 64 bits.
  - parity_out = stored parity of the head entry while slice_valid=1, else 0.
- Not defined:
  - No extra storage.
  - parity_out tied to 0.

Test Plan:
- Reset then single issue: reset low 3 cycles; in_valid at cycle 10; core_out=64'h0123_4567_89AB_CDEF at cycle 10+PIPE_LAT -> slice_valid=1 with slice_out=16'h0123, idx 0. Three rd_next pulses -> 4567, 89AB, CDEF. Fourth rd_next -> slice_valid=0, fifo_count=0.
- Latency alignment: in_valid at t=0; core_out changes every cycle to its cycle number -> captured value equals PIPE_LAT exactly (not PIPE_LAT±1).
- Overflow: DEPTH=4; 5 back-to-back in_valid, no rd_next -> fifo_count=4, overflow=1. Readout yields the first 4 values in order.
- Full with simultaneous pop: FIFO full, 4th rd_next coincides with cap -> no overflow, fifo_count stays 4, FIFO order preserved.
- Reset mid-readout: at slice_idx=2 with 3 entries queued, assert reset -> all outputs 0 immediately; after release, no stale data appears.
- With DES_OUT_PARITY_EN: capture 64'h1 then 64'h3 -> parity_out=1 on the first entry, 0 on the second. Without the macro, parity_out stays 0.
